// File: rtl/poci_led_arbiter.sv
// rtl/poci_led_arbiter.sv - round-robin two-requester POCI master for the LED peripheral
// Optional ACCESS watchdog: define POCI_LED_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module poci_led_arbiter #(
  parameter logic [31:0] ADDR_HEX  = 32'h0000_0000,
  parameter logic [31:0] ADDR_LEDG = 32'h0000_0004,
  parameter logic [31:0] ADDR_LEDR = 32'h0000_0008,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic [1:0]  req_i,
  input  logic [1:0]  req_write_i,
  input  logic [1:0]  req_sel0_i,
  input  logic [1:0]  req_sel1_i,
  input  logic [31:0] req_wdata0_i,
  input  logic [31:0] req_wdata1_i,
  output logic [1:0]  ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] m_paddr_o,
  output logic        m_psel_o,
  output logic        m_penable_o,
  output logic        m_pwrite_o,
  output logic [31:0] m_pwdata_o,
  input  logic [31:0] m_prdata_i,
  input  logic        m_pready_i,
  input  logic        m_pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, FAIL} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr;
  logic        in_xfer;

`ifdef POCI_LED_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      // "last granted = 1" makes requester 0 win the first contested round
      last_q  <= 1'b1;
      write_q <= 1'b0;
      sel_q   <= 2'd0;
      wdata_q <= 32'd0;
`ifdef POCI_LED_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
`ifdef POCI_LED_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    write_d     = write_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    ack_o       = 2'b00;
    rdata_o     = 32'd0;
    err_o       = 1'b0;
    m_psel_o    = 1'b0;
    m_penable_o = 1'b0;
`ifdef POCI_LED_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = (req_i == 2'b11) ? ~last_q : req_i[1];
          last_d  = grant_d;
          write_d = req_write_i[grant_d];
          sel_d   = grant_d ? req_sel1_i : req_sel0_i;
          wdata_d = grant_d ? req_wdata1_i : req_wdata0_i;
          state_d = (sel_d == 2'd3) ? FAIL : SETUP;
`ifdef POCI_LED_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      SETUP: begin
        m_psel_o = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        m_psel_o    = 1'b1;
        m_penable_o = 1'b1;
        if (m_pready_i) begin
          ack_o   = grant_q ? 2'b10 : 2'b01;
          rdata_o = m_prdata_i;
          err_o   = m_pslverr_i;
          state_d = IDLE;
        end
`ifdef POCI_LED_ARB_TIMEOUT_EN
        else begin
          // FAIL doubles as the timeout completion: no bus, err=1, rdata=0
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) state_d = FAIL;
        end
`endif
      end
      FAIL: begin
        ack_o   = grant_q ? 2'b10 : 2'b01;
        err_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (sel_q)
      2'd0:    addr = ADDR_HEX;
      2'd1:    addr = ADDR_LEDG;
      default: addr = ADDR_LEDR;
    endcase
  end

  assign in_xfer    = (state_q == SETUP) || (state_q == ACCESS);
  assign m_paddr_o  = in_xfer ? addr : 32'd0;
  assign m_pwrite_o = in_xfer & write_q;
  assign m_pwdata_o = in_xfer ? wdata_q : 32'd0;

endmodule
